// File: rtl/gaussian_pkg.sv
// Shared definitions for the 7x7 Gaussian datapath.
// Contents:
//   PIX_W, K  - pixel width and window edge
//   WIN_W     - width of a packed KxK window
//   pix_t     - one pixel
//   win_lsb() - LSB of window pixel (r, c); row 0 / column 0 are the oldest,
//               so the top-left pixel lands in the MSBs and the newest in [7:0].
package gaussian_pkg;
  localparam int PIX_W = 8;
  localparam int K     = 7;
  localparam int WIN_W = K * K * PIX_W;

  typedef logic [PIX_W-1:0] pix_t;

  function automatic int win_lsb(input int r, input int c);
    return PIX_W * (K * K - 1 - (K * r + c));
  endfunction
endpackage

// File: rtl/gaussian_window_gen_if.sv
// Pixel-stream / window bus between the raster source, the window generator
// and the Gaussian core.
// Signals:
//   pix_in, pix_valid, sof      - raster pixel stream into the generator
//   window, win_valid, frame_done - packed KxK window out of the generator
// Handshake: pix_valid qualifies pix_in and sof for one cycle; there is no
// ready, because the consumer is combinational and always accepts. win_valid
// and frame_done are single-cycle strobes.
// Modports: master = pixel source / window consumer, slave = window generator.
interface gaussian_window_gen_if;
  import gaussian_pkg::*;

  pix_t             pix_in;
  logic             pix_valid;
  logic             sof;
  logic [WIN_W-1:0] window;
  logic             win_valid;
  logic             frame_done;

  modport master (
    output pix_in, pix_valid, sof,
    input  window, win_valid, frame_done
  );

  modport slave (
    input  pix_in, pix_valid, sof,
    output window, win_valid, frame_done
  );
endinterface

// File: rtl/gaussian_line_buffer.sv
// One-row delay line: dout_o is the pixel written DEPTH enabled cycles ago.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset (pointer only)
//   en_i       - advance the delay line by one pixel
//   din_i      - pixel written this cycle
//   dout_o     - pixel leaving the delay line (read before overwrite)
// A single pointer serves read and write: the slot about to be overwritten
// holds exactly the pixel from one row earlier. Storage is not reset.
module gaussian_line_buffer
  import gaussian_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  pix_t din_i,
  output pix_t dout_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  pix_t          mem_q [DEPTH];
  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (en_i) begin
      ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (en_i) begin
      mem_q[ptr_q] <= din_i;
    end
  end

  assign dout_o = mem_q[ptr_q];
endmodule

// File: rtl/gaussian_window_gen.sv
// Streaming KxK window generator feeding the Gaussian core.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   bus   - slave side of gaussian_window_gen_if (pixel in, window out)
// K-1 line buffers provide the vertical tap column; a KxK register window
// shifts left on every accepted pixel. win_valid pulses one cycle after an
// accepted pixel whose coordinate completes an interior window.
module gaussian_window_gen
  import gaussian_pkg::*;
#(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gaussian_window_gen_if.slave bus
);
  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  logic [CW-1:0]    col_q, col_d, cur_col;
  logic [RW-1:0]    row_q, row_d, cur_row;
  logic [WIN_W-1:0] win_q, win_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;

  // tap[i] is the pixel i rows above the incoming one, same column.
  pix_t tap [K];

  assign tap[0] = bus.pix_in;

  for (genvar g = 0; g < K - 1; g++) begin : g_lb
    gaussian_line_buffer #(.DEPTH(IMG_WIDTH)) u_lb (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (bus.pix_valid),
      .din_i  (tap[g]),
      .dout_o (tap[g+1])
    );
  end

  // sof relabels the current pixel as (0,0) whatever the counters say.
  assign cur_col = bus.sof ? '0 : col_q;
  assign cur_row = bus.sof ? '0 : row_q;

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    win_d   = win_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    if (bus.pix_valid) begin
      if (cur_col == CW'(IMG_WIDTH - 1)) begin
        col_d = '0;
        row_d = (cur_row == RW'(IMG_HEIGHT - 1)) ? '0 : cur_row + 1'b1;
      end else begin
        col_d = cur_col + 1'b1;
        row_d = cur_row;
      end
      valid_d = (cur_row >= RW'(K - 1)) && (cur_col >= CW'(K - 1));
      done_d  = (cur_row == RW'(IMG_HEIGHT - 1)) && (cur_col == CW'(IMG_WIDTH - 1));
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          win_d[win_lsb(r, c) +: PIX_W] = win_q[win_lsb(r, c + 1) +: PIX_W];
        end
        win_d[win_lsb(r, K - 1) +: PIX_W] = tap[K - 1 - r];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q   <= '0;
      row_q   <= '0;
      win_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      win_q   <= win_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign bus.window     = win_q;
  assign bus.win_valid  = valid_q;
  assign bus.frame_done = done_q;
endmodule

// File: tb/tb_gaussian_window_gen.sv
module tb_gaussian_window_gen;
  import gaussian_pkg::*;

  localparam int W = 8;
  localparam int H = 8;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gaussian_window_gen_if bus();

  gaussian_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  int               n_vec = 0;
  int               n_err = 0;
  int               mr = 0;
  int               mc = 0;
  logic [7:0]       img [H][W];
  logic [WIN_W-1:0] win_log [$];
  logic [WIN_W-1:0] ref_log [$];
  logic [WIN_W-1:0] all_ff;

  task automatic check(input string tag, input logic [WIN_W-1:0] obs,
                       input logic [WIN_W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // One accepted pixel; the bench model tracks its coordinate and predicts
  // win_valid, frame_done and the full window from the stored image.
  task automatic step(input logic [7:0] p, input logic s);
    logic [WIN_W-1:0] exp_win;
    logic             exp_v;
    logic             exp_d;
    @(negedge clk);
    bus.pix_in    = p;
    bus.pix_valid = 1'b1;
    bus.sof       = s;
    if (s) begin
      mr = 0;
      mc = 0;
    end
    img[mr][mc] = p;
    exp_v   = (mr >= K - 1) && (mc >= K - 1);
    exp_d   = (mr == H - 1) && (mc == W - 1);
    exp_win = '0;
    if (exp_v) begin
      for (int wr = 0; wr < K; wr++)
        for (int wc = 0; wc < K; wc++)
          exp_win[PIX_W*(K*K-1-(K*wr+wc)) +: PIX_W] = img[mr-(K-1)+wr][mc-(K-1)+wc];
    end
    @(posedge clk);
    #1;
    bus.sof = 1'b0;
    check("win_valid", WIN_W'(bus.win_valid), WIN_W'(exp_v));
    check("frame_done", WIN_W'(bus.frame_done), WIN_W'(exp_d));
    if (exp_v) check("window", bus.window, exp_win);
    if (bus.win_valid === 1'b1) win_log.push_back(bus.window);
    mc++;
    if (mc == W) begin
      mc = 0;
      mr++;
      if (mr == H) mr = 0;
    end
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.pix_valid = 1'b0;
      bus.sof       = 1'b0;
      bus.pix_in    = 8'($urandom_range(0, 255));
      @(posedge clk);
      #1;
      check("gap_valid", WIN_W'(bus.win_valid), '0);
      check("gap_done", WIN_W'(bus.frame_done), '0);
    end
  endtask

  task automatic send_frame(input logic first_sof, input logic ff, input logic gaps);
    for (int i = 0; i < W * H; i++) begin
      step(ff ? 8'hFF : 8'(i), first_sof && (i == 0));
      if (gaps) gap($urandom_range(1, 5));
    end
  endtask

  task automatic spot(input string tag, input int idx, input logic [7:0] tl,
                      input logic [7:0] br);
    logic [WIN_W-1:0] w;
    w = (idx < win_log.size()) ? win_log[idx] : '0;
    check({tag, "_tl"}, WIN_W'(w[WIN_W-1 -: PIX_W]), WIN_W'(tl));
    check({tag, "_br"}, WIN_W'(w[PIX_W-1:0]), WIN_W'(br));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    all_ff        = {49{8'hFF}};
    bus.pix_in    = '0;
    bus.pix_valid = 1'b0;
    bus.sof       = 1'b0;

    // reset state
    #2;
    check("rst_window", bus.window, '0);
    check("rst_valid", WIN_W'(bus.win_valid), '0);
    check("rst_done", WIN_W'(bus.frame_done), '0);
    @(negedge clk);
    rst_n = 1'b1;

    // continuous frame
    win_log.delete();
    send_frame(1'b1, 1'b0, 1'b0);
    check("t1_count", WIN_W'(win_log.size()), WIN_W'(4));
    spot("t1_w0", 0, 8'd0, 8'd54);
    check("t1_w0_centre", WIN_W'(win_log.size() > 0 ? win_log[0][win_lsb(3, 3) +: PIX_W] : 8'd0),
          WIN_W'(27));
    spot("t1_w1", 1, 8'd1, 8'd55);
    spot("t1_w2", 2, 8'd8, 8'd62);
    check("t1_w3_br", WIN_W'(win_log.size() > 3 ? win_log[3][PIX_W-1:0] : 8'd0), WIN_W'(63));
    ref_log = win_log;

    // same frame with stalls
    win_log.delete();
    send_frame(1'b1, 1'b0, 1'b1);
    check("t2_count", WIN_W'(win_log.size()), WIN_W'(4));
    for (int i = 0; i < 4; i++)
      check("t2_same", (i < win_log.size()) ? win_log[i] : '0,
            (i < ref_log.size()) ? ref_log[i] : '1);

    // two back-to-back frames, sof only on the first
    win_log.delete();
    send_frame(1'b1, 1'b0, 1'b0);
    send_frame(1'b0, 1'b0, 1'b0);
    check("t3_count", WIN_W'(win_log.size()), WIN_W'(8));
    spot("t3_w4", 4, 8'd0, 8'd54);

    // mid-frame sof abandons the partial frame
    win_log.delete();
    for (int i = 0; i < 40; i++) step(8'(i), i == 0);
    send_frame(1'b1, 1'b0, 1'b0);
    check("t4_count", WIN_W'(win_log.size()), WIN_W'(4));
    spot("t4_w0", 0, 8'd0, 8'd54);

    // asynchronous reset mid-frame
    win_log.delete();
    for (int i = 0; i < 50; i++) step(8'(i), i == 0);
    @(negedge clk);
    bus.pix_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("t5_rst_window", bus.window, '0);
    check("t5_rst_valid", WIN_W'(bus.win_valid), '0);
    #1 rst_n = 1'b1;
    mr = 0;
    mc = 0;
    send_frame(1'b0, 1'b0, 1'b0);
    check("t5_count", WIN_W'(win_log.size()), WIN_W'(4));
    spot("t5_w0", 0, 8'd0, 8'd54);

    // saturated pixels
    win_log.delete();
    send_frame(1'b1, 1'b1, 1'b0);
    check("t6_count", WIN_W'(win_log.size()), WIN_W'(4));
    for (int i = 0; i < 4; i++)
      check("t6_all_ff", (i < win_log.size()) ? win_log[i] : '0, all_ff);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
